// File: rtl/cmd_frame_pkg.sv
// Shared types and frame-layout constants for the command frame decoder.
package cmd_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        DATA,
        CSUM,
        ISSUE
    } frame_state_e;

    localparam int ADDR_BYTES  = 2;
    localparam int DATA_BYTES  = 4;
    localparam int FRAME_BYTES = 8;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/cmd_frame_decoder.sv
// Byte-stream framer: hunts SYNC, collects big-endian addr/data, checks XOR csum,
// and emits a one-cycle register write per good frame.
module cmd_frame_decoder
    import cmd_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         ADDR_WIDTH     = 16,
    parameter int         DATA_WIDTH     = 32,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         CNT_WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [DATA_WIDTH-1:0] cmd_data_o,
    output logic                  cmd_valid_o,
    output logic [CNT_WIDTH-1:0]  csum_err_count_o,
    output logic [CNT_WIDTH-1:0]  timeout_count_o,
    output logic                  busy_o
);

    localparam int IDX_W = $clog2(FRAME_BYTES);
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

    frame_state_e r_state;
    frame_state_e w_next;

    logic [IDX_W-1:0]      r_idx;
    logic [GAP_W-1:0]      r_gap;
    logic [15:0]           r_addr_sh;
    logic [31:0]           r_data_sh;
    logic [7:0]            r_csum;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_data;

    logic w_accept;
    logic w_in_frame;
    logic w_timeout;
    logic w_csum_ok;
    logic w_csum_bad;

    assign byte_ready_o = (r_state != ISSUE);
    assign w_accept     = byte_valid_i && byte_ready_o;
    assign w_in_frame   = (r_state == ADDR) || (r_state == DATA) || (r_state == CSUM);
    // A byte arriving on the expiry cycle wins, so expiry requires an idle input.
    assign w_timeout    = w_in_frame && !byte_valid_i && (r_gap == GAP_LAST);
    assign w_csum_ok    = (r_state == CSUM) && w_accept && (byte_i == r_csum);
    assign w_csum_bad   = (r_state == CSUM) && w_accept && (byte_i != r_csum);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HUNT:    if (w_accept && (byte_i == SYNC_BYTE)) w_next = ADDR;
            ADDR:    if (w_accept && (r_idx == ADDR_LAST))  w_next = DATA;
            DATA:    if (w_accept && (r_idx == DATA_LAST))  w_next = CSUM;
            CSUM:    if (w_accept) w_next = w_csum_ok ? ISSUE : HUNT;
            ISSUE:   w_next = HUNT;
            default: w_next = HUNT;
        endcase
        if (w_timeout) begin
            w_next = HUNT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_idx <= '0;
            r_gap <= '0;
        end else begin
            case (r_state)
                ADDR:    if (w_accept) r_idx <= (r_idx == ADDR_LAST) ? '0 : r_idx + 1'b1;
                DATA:    if (w_accept) r_idx <= (r_idx == DATA_LAST) ? '0 : r_idx + 1'b1;
                default: r_idx <= '0;
            endcase
            if (!w_in_frame || w_accept || w_timeout) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    // Field assembly; contents only matter once a frame completes, so no reset.
    always_ff @(posedge clk_i) begin
        if (r_state == HUNT) begin
            r_csum <= '0;
        end else if (w_accept && (r_state == ADDR)) begin
            r_addr_sh <= {r_addr_sh[7:0], byte_i};
            r_csum    <= r_csum ^ byte_i;
        end else if (w_accept && (r_state == DATA)) begin
            r_data_sh <= {r_data_sh[23:0], byte_i};
            r_csum    <= r_csum ^ byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cmd_addr <= '0;
            r_cmd_data <= '0;
        end else if (w_csum_ok) begin
            r_cmd_addr <= ADDR_WIDTH'(r_addr_sh);
            r_cmd_data <= DATA_WIDTH'(r_data_sh);
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_csum_err_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_csum_bad),
        .count_o (csum_err_count_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (w_timeout),
        .count_o (timeout_count_o)
    );

    assign cmd_addr_o  = r_cmd_addr;
    assign cmd_data_o  = r_cmd_data;
    assign cmd_valid_o = (r_state == ISSUE);
    assign busy_o      = (r_state != HUNT);

endmodule
